// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the hazard controller and the pipeline: decode/EX
// register addresses, memory request/response strobes and stage controls.
interface pipe_hazard_ctrl_if #(
  parameter int NSTAGE = 5,
  parameter int RA_W   = 5
);
  localparam int SEL_W = $clog2(NSTAGE);

  logic              id_valid;
  logic [RA_W-1:0]   id_rs1_s;
  logic [RA_W-1:0]   id_rs2_s;
  logic [RA_W-1:0]   id_rd_s;
  logic              id_we;
  logic              id_is_load;
  logic [RA_W-1:0]   ex_rs1_s;
  logic [RA_W-1:0]   ex_rs2_s;
  logic              br_taken;
  // Handshake: a one-cycle *_req pulse opens an outstanding access and the
  // matching one-cycle *_resp pulse closes it; a resp that coincides with a
  // new req completes the older access and leaves the new one outstanding.
  logic              imem_req;
  logic              imem_resp;
  logic              dmem_req;
  logic              dmem_resp;
  logic [NSTAGE-1:0] stage_en;
  logic [NSTAGE-1:0] stage_flush;
  logic [SEL_W-1:0]  fwd_rs1_sel;
  logic [SEL_W-1:0]  fwd_rs2_sel;
  logic              freeze;
  logic              stall;
  logic [31:0]       perf_freeze;
  logic [31:0]       perf_stall;
  logic [31:0]       perf_flush;

  modport master (
    output id_valid, id_rs1_s, id_rs2_s, id_rd_s, id_we, id_is_load,
    output ex_rs1_s, ex_rs2_s, br_taken,
    output imem_req, imem_resp, dmem_req, dmem_resp,
    input  stage_en, stage_flush, fwd_rs1_sel, fwd_rs2_sel, freeze, stall,
    input  perf_freeze, perf_stall, perf_flush
  );

  modport slave (
    input  id_valid, id_rs1_s, id_rs2_s, id_rd_s, id_we, id_is_load,
    input  ex_rs1_s, ex_rs2_s, br_taken,
    input  imem_req, imem_resp, dmem_req, dmem_resp,
    output stage_en, stage_flush, fwd_rs1_sel, fwd_rs2_sel, freeze, stall,
    output perf_freeze, perf_stall, perf_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline freeze/flush/stall and EX forwarding control for the in-order RV32I core.
// Optional saturating hazard counters are built when HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int NSTAGE   = 5,
    parameter int BR_STAGE = 3,
    parameter int RA_W     = 5
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int SEL_W = $clog2(NSTAGE);

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd_s;
        logic            we;
        logic            is_load;
    } sb_t;

    // sb[i] shadows pipeline register i (2 = ID/EX ... NSTAGE-1 = MEM/WB)
    sb_t  sb [2:NSTAGE-1];
    logic imem_pend;
    logic dmem_pend;
    logic freeze_c;
    logic ld_use;
    logic stall_c;
    logic br_c;
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel2;

    always_comb begin
        freeze_c = (imem_pend & ~hz.imem_resp) | (dmem_pend & ~hz.dmem_resp);
    end

    always_comb begin
        ld_use = 1'b0;
        for (int j = 2; j <= NSTAGE - 2; j++) begin
            if (sb[j].valid && sb[j].we && sb[j].is_load && (sb[j].rd_s != '0) &&
                ((sb[j].rd_s == hz.id_rs1_s) || (sb[j].rd_s == hz.id_rs2_s)))
                ld_use = 1'b1;
        end
        ld_use  = ld_use & hz.id_valid;
        br_c    = hz.br_taken & ~freeze_c;
        stall_c = ld_use & ~freeze_c & ~hz.br_taken;
    end

    // Scan oldest to youngest so the youngest eligible producer wins.
    always_comb begin
        sel1 = '0;
        sel2 = '0;
        for (int k = NSTAGE - 3; k >= 1; k--) begin
            if (sb[2+k].valid && sb[2+k].we && (!sb[2+k].is_load || k == NSTAGE - 3)) begin
                if ((hz.ex_rs1_s != '0) && (sb[2+k].rd_s == hz.ex_rs1_s)) sel1 = SEL_W'(k);
                if ((hz.ex_rs2_s != '0) && (sb[2+k].rd_s == hz.ex_rs2_s)) sel2 = SEL_W'(k);
            end
        end
    end

    always_comb begin
        hz.stage_en    = '1;
        hz.stage_flush = '0;
        if (rst) begin
            hz.stage_en    = '0;
            hz.stage_flush = '1;
        end else if (freeze_c) begin
            hz.stage_en = '0;
        end else if (hz.br_taken) begin
            for (int i = 1; i < NSTAGE; i++) begin
                if (i < BR_STAGE) hz.stage_flush[i] = 1'b1;
            end
        end else if (ld_use) begin
            hz.stage_en[1:0]  = 2'b00;
            hz.stage_flush[2] = 1'b1;
        end
        hz.freeze      = freeze_c & ~rst;
        hz.stall       = stall_c & ~rst;
        hz.fwd_rs1_sel = rst ? '0 : sel1;
        hz.fwd_rs2_sel = rst ? '0 : sel2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_pend <= 1'b0;
            dmem_pend <= 1'b0;
            for (int i = 2; i < NSTAGE; i++) sb[i] <= '0;
        end else begin
            imem_pend <= hz.imem_req | (imem_pend & ~hz.imem_resp);
            dmem_pend <= hz.dmem_req | (dmem_pend & ~hz.dmem_resp);
            if (!freeze_c) begin
                for (int i = NSTAGE - 1; i >= 3; i--) sb[i] <= sb[i-1];
                sb[2] <= stall_c ? '0 : {hz.id_valid, hz.id_rd_s, hz.id_we, hz.id_is_load};
                if (hz.br_taken) begin
                    for (int i = 2; i < NSTAGE; i++) begin
                        if (i < BR_STAGE) sb[i] <= '0;
                    end
                end
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] cnt_freeze;
    logic [31:0] cnt_stall;
    logic [31:0] cnt_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_freeze <= '0;
            cnt_stall  <= '0;
            cnt_flush  <= '0;
        end else begin
            if (freeze_c && (cnt_freeze != '1)) cnt_freeze <= cnt_freeze + 32'd1;
            if (stall_c && (cnt_stall != '1))   cnt_stall  <= cnt_stall + 32'd1;
            if (br_c && (cnt_flush != '1))      cnt_flush  <= cnt_flush + 32'd1;
        end
    end

    assign hz.perf_freeze = cnt_freeze;
    assign hz.perf_stall  = cnt_stall;
    assign hz.perf_flush  = cnt_flush;
`else
    assign hz.perf_freeze = '0;
    assign hz.perf_stall  = '0;
    assign hz.perf_flush  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios then random traffic,
// checked each cycle against a queue-based model of the in-flight instructions.
module tb_pipe_hazard_ctrl;
    localparam int NSTAGE   = 5;
    localparam int BR_STAGE = 3;
    localparam int RA_W     = 5;
    localparam int DEPTH    = NSTAGE - 2;

    typedef struct {
        bit valid;
        int rd;
        bit we;
        bit ld;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pipe_hazard_ctrl_if #(.NSTAGE(NSTAGE), .RA_W(RA_W)) hz ();

    pipe_hazard_ctrl #(.NSTAGE(NSTAGE), .BR_STAGE(BR_STAGE), .RA_W(RA_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // pq[0] is the youngest in-flight instruction (register 2), pq[DEPTH-1] is WB
    ent_t   pq[$];
    bit     m_ipend, m_dpend;
    longint m_pf, m_ps, m_pl;
    bit     e_freeze, e_stall, e_br;
    logic [NSTAGE-1:0] e_en, e_flush;
    int     e_f1, e_f2;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(int rs);
        if (rs == 0) return 0;
        for (int k = 1; k < DEPTH; k++)
            if (pq[k].valid && pq[k].we && pq[k].rd == rs && (!pq[k].ld || k == DEPTH - 1))
                return k;
        return 0;
    endfunction

    task automatic expect_now();
        bit hazard;
        hazard = 0;
        e_freeze = (m_ipend && !hz.imem_resp) || (m_dpend && !hz.dmem_resp);
        for (int j = 0; j < DEPTH - 1; j++)
            if (pq[j].valid && pq[j].we && pq[j].ld && pq[j].rd != 0 &&
                (pq[j].rd == int'(hz.id_rs1_s) || pq[j].rd == int'(hz.id_rs2_s)))
                hazard = 1;
        hazard  = hazard && hz.id_valid;
        e_br    = hz.br_taken && !e_freeze;
        e_stall = hazard && !e_freeze && !hz.br_taken;
        e_en    = '1;
        e_flush = '0;
        if (e_freeze) e_en = '0;
        else if (hz.br_taken) e_flush = NSTAGE'((1 << BR_STAGE) - 2);
        else if (hazard) begin
            e_en    = ~NSTAGE'(3);
            e_flush = NSTAGE'(1 << 2);
        end
        e_f1 = pick(int'(hz.ex_rs1_s));
        e_f2 = pick(int'(hz.ex_rs2_s));
    endtask

    task automatic update_model();
        ent_t n;
        if (rst) begin
            n = '{0, 0, 0, 0};
            pq.delete();
            repeat (DEPTH) pq.push_back(n);
            m_ipend = 0; m_dpend = 0;
            m_pf = 0; m_ps = 0; m_pl = 0;
            return;
        end
        if (e_freeze && m_pf < 64'hFFFF_FFFF) m_pf++;
        if (e_stall && m_ps < 64'hFFFF_FFFF) m_ps++;
        if (e_br && m_pl < 64'hFFFF_FFFF) m_pl++;
        if (!e_freeze) begin
            if (e_stall) n = '{0, 0, 0, 0};
            else n = '{hz.id_valid, int'(hz.id_rd_s), hz.id_we, hz.id_is_load};
            pq.push_front(n);
            void'(pq.pop_back());
            if (e_br) for (int i = 0; i < BR_STAGE - 2; i++) pq[i].valid = 0;
        end
        m_ipend = hz.imem_req || (m_ipend && !hz.imem_resp);
        m_dpend = hz.dmem_req || (m_dpend && !hz.dmem_resp);
    endtask

    task automatic step();
        longint pf, ps, pl;
        #1;
        expect_now();
`ifdef HAZARD_PERF_EN
        pf = m_pf; ps = m_ps; pl = m_pl;
`else
        pf = 0; ps = 0; pl = 0;
`endif
        if (rst) begin
            chk("rst_stage_en", 32'(hz.stage_en), 32'(0));
            chk("rst_stage_flush", 32'(hz.stage_flush), 32'({NSTAGE{1'b1}}));
            chk("rst_freeze", 32'(hz.freeze), 32'(0));
            chk("rst_stall", 32'(hz.stall), 32'(0));
            chk("rst_fwd_rs1_sel", 32'(hz.fwd_rs1_sel), 32'(0));
            chk("rst_fwd_rs2_sel", 32'(hz.fwd_rs2_sel), 32'(0));
        end else begin
            chk("stage_en", 32'(hz.stage_en), 32'(e_en));
            chk("stage_flush", 32'(hz.stage_flush), 32'(e_flush));
            chk("freeze", 32'(hz.freeze), 32'(e_freeze));
            chk("stall", 32'(hz.stall), 32'(e_stall));
            chk("fwd_rs1_sel", 32'(hz.fwd_rs1_sel), 32'(e_f1));
            chk("fwd_rs2_sel", 32'(hz.fwd_rs2_sel), 32'(e_f2));
        end
        chk("perf_freeze", hz.perf_freeze, 32'(pf));
        chk("perf_stall", hz.perf_stall, 32'(ps));
        chk("perf_flush", hz.perf_flush, 32'(pl));
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic drive_id(bit v, int rs1, int rs2, int rd, bit we, bit ld);
        hz.id_valid   = v;
        hz.id_rs1_s   = RA_W'(rs1);
        hz.id_rs2_s   = RA_W'(rs2);
        hz.id_rd_s    = RA_W'(rd);
        hz.id_we      = we;
        hz.id_is_load = ld;
    endtask

    task automatic idle();
        drive_id(0, 0, 0, 0, 0, 0);
        hz.ex_rs1_s  = '0;
        hz.ex_rs2_s  = '0;
        hz.br_taken  = 1'b0;
        hz.imem_req  = 1'b0;
        hz.imem_resp = 1'b0;
        hz.dmem_req  = 1'b0;
        hz.dmem_resp = 1'b0;
    endtask

    initial begin
        ent_t bub;
        bub = '{0, 0, 0, 0};
        repeat (DEPTH) pq.push_back(bub);
        m_ipend = 0; m_dpend = 0;
        m_pf = 0; m_ps = 0; m_pl = 0;
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        rst = 1'b0;

        // back-to-back ALU producers: forward distance 1, 2, and x0 never forwarded
        drive_id(1, 1, 2, 5, 1, 0); step();
        drive_id(1, 3, 4, 6, 1, 0); step();
        drive_id(1, 5, 0, 0, 1, 0); hz.ex_rs1_s = 5; hz.ex_rs2_s = 0; step();
        drive_id(1, 6, 5, 8, 1, 0); hz.ex_rs1_s = 5; hz.ex_rs2_s = 6; step();
        drive_id(0, 0, 0, 0, 0, 0); hz.ex_rs1_s = 0; hz.ex_rs2_s = 8; step();

        // load-use with the load entering register 2, then WB forwarding select
        idle(); repeat (3) step();
        drive_id(1, 0, 0, 7, 1, 1); step();
        drive_id(1, 7, 0, 9, 1, 0); repeat (2) step();
        hz.ex_rs1_s = 7; step();
        idle(); hz.ex_rs1_s = 9; step();

        // consumer one slot behind the load: a single stall cycle
        idle(); repeat (3) step();
        drive_id(1, 0, 0, 7, 1, 1); step();
        drive_id(1, 1, 1, 10, 1, 0); step();
        drive_id(1, 1, 7, 11, 1, 0); step();
        hz.ex_rs2_s = 7; step();

        // fetch wait: request at cycle 0, response at cycle 4
        idle(); hz.imem_req = 1; step();
        hz.imem_req = 0; drive_id(1, 2, 3, 4, 1, 0); repeat (3) step();
        hz.imem_resp = 1; step();
        hz.imem_resp = 0; step();

        // branch beats a coincident load-use stall
        idle(); repeat (3) step();
        drive_id(1, 0, 0, 7, 1, 1); step();
        drive_id(1, 7, 0, 12, 1, 0); hz.br_taken = 1; step();
        hz.br_taken = 0; step();

        // data wait holds off both branch and stall until the response
        idle(); repeat (3) step();
        drive_id(1, 0, 0, 7, 1, 1); hz.dmem_req = 1; step();
        hz.dmem_req = 0; drive_id(1, 7, 0, 12, 1, 0); hz.br_taken = 1; repeat (2) step();
        hz.dmem_resp = 1; step();
        hz.dmem_resp = 0; hz.br_taken = 0; step();

        // reset in the middle of a fetch wait
        idle(); hz.imem_req = 1; step();
        hz.imem_req = 0; repeat (2) step();
        rst = 1; step();
        rst = 0; repeat (2) step();

        for (int c = 0; c < 400; c++) begin
            drive_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3);
            hz.ex_rs1_s  = RA_W'($urandom_range(0, 3));
            hz.ex_rs2_s  = RA_W'($urandom_range(0, 3));
            hz.br_taken  = ($urandom_range(0, 9) == 0);
            hz.imem_req  = ($urandom_range(0, 11) == 0);
            hz.imem_resp = ($urandom_range(0, 2) == 0);
            hz.dmem_req  = ($urandom_range(0, 11) == 0);
            hz.dmem_resp = ($urandom_range(0, 2) == 0);
            rst          = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 0;
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
